// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
// Segment constants are active-high, bit order g,f,e,d,c,b,a.
package calc_pkg;

    typedef enum logic [1:0] {
        BLANK,
        SHOW,
        ERR
    } state_t;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_R     = 7'h50;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Non-BCD codes reused by the encoder to draw the "Er" glyphs
    localparam logic [BCD_W-1:0] DIG_E = 4'hE;
    localparam logic [BCD_W-1:0] DIG_R = 4'hF;

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD-to-seven-segment encoder with blanking and optional
// active-low output polarity.
module seg7_encode
    import calc_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    logic [SEG_W-1:0] seg_hi;

    always_comb begin
        seg_hi = SEG_BLANK;
        if (!blank) begin
            unique case (digit)
                4'd0:    seg_hi = SEG_0;
                4'd1:    seg_hi = SEG_1;
                4'd2:    seg_hi = SEG_2;
                4'd3:    seg_hi = SEG_3;
                4'd4:    seg_hi = SEG_4;
                4'd5:    seg_hi = SEG_5;
                4'd6:    seg_hi = SEG_6;
                4'd7:    seg_hi = SEG_7;
                4'd8:    seg_hi = SEG_8;
                4'd9:    seg_hi = SEG_9;
                DIG_E:   seg_hi = SEG_E;
                DIG_R:   seg_hi = SEG_R;
                default: seg_hi = SEG_BLANK;
            endcase
        end
    end

    assign seg = ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Two-digit seven-segment display controller: captures a BCD pair on load,
// optionally blanks a leading zero, and blinks "Er" on overflow/invalid input.
module seg7_display_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned BLINK_HALF = 25000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [BCD_W-1:0] tens,
    input  logic [BCD_W-1:0] ones,
    input  logic             err,
    input  logic             blank_lz,
    output logic [SEG_W-1:0] hex1,
    output logic [SEG_W-1:0] hex0,
    output logic             showing
);

    localparam int unsigned      CNT_W      = $clog2(BLINK_HALF);
    localparam logic [SEG_W-1:0] BLANK_CODE = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   tens_q, ones_q;
    logic [CNT_W-1:0]   blink_cnt;
    logic               phase_on;
    logic               load_ok, load_bad;

    logic [BCD_W-1:0]   digit1, digit0;
    logic               blank1, blank0;
    logic [SEG_W-1:0]   seg1, seg0;

    assign load_bad = load && !clear && (err || bcd_invalid(tens) || bcd_invalid(ones));
    assign load_ok  = load && !clear && !load_bad;

    always_ff @(posedge clk1) begin
        if (reset) state <= BLANK;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear)         state_nxt = BLANK;
        else if (load_bad) state_nxt = ERR;
        else if (load_ok)  state_nxt = SHOW;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            tens_q <= '0;
            ones_q <= '0;
        end else if (load_ok) begin
            tens_q <= tens;
            ones_q <= ones;
        end
    end

    // Counter only runs while staying in ERR; any entry (or re-entry) restarts it
    always_ff @(posedge clk1) begin
        if (reset || load_bad || state != ERR || state_nxt != ERR) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == CNT_W'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        digit1 = '0;
        digit0 = '0;
        blank1 = 1'b1;
        blank0 = 1'b1;
        unique case (state)
            SHOW: begin
                digit1 = tens_q;
                digit0 = ones_q;
                blank1 = blank_lz && (tens_q == '0);
                blank0 = 1'b0;
            end
            ERR: begin
                digit1 = DIG_E;
                digit0 = DIG_R;
                blank1 = !phase_on;
                blank0 = !phase_on;
            end
            default: ;
        endcase
    end

    seg7_encode #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc1 (
        .digit (digit1),
        .blank (blank1),
        .seg   (seg1)
    );

    seg7_encode #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc0 (
        .digit (digit0),
        .blank (blank0),
        .seg   (seg0)
    );

    always_ff @(posedge clk1) begin
        if (reset) begin
            hex1    <= BLANK_CODE;
            hex0    <= BLANK_CODE;
            showing <= 1'b0;
        end else begin
            hex1    <= seg1;
            hex0    <= seg0;
            showing <= (state != BLANK);
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed self-checking bench for seg7_display_ctrl (BLINK_HALF=4, active-low).
module tb_seg7_display_ctrl;

    logic       clk1 = 1'b0;
    logic       reset, load, clear, err, blank_lz;
    logic [3:0] tens, ones;
    logic [6:0] hex1, hex0;
    logic       showing;

    int checks = 0;
    int errors = 0;

    seg7_display_ctrl #(.BLINK_HALF(4), .ACTIVE_LOW(1'b1)) dut (
        .clk1     (clk1),
        .reset    (reset),
        .load     (load),
        .clear    (clear),
        .tens     (tens),
        .ones     (ones),
        .err      (err),
        .blank_lz (blank_lz),
        .hex1     (hex1),
        .hex0     (hex0),
        .showing  (showing)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o, input logic e);
        tens = t; ones = o; err = e; load = 1'b1;
        tick();
        load = 1'b0; err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (hex1 !== 7'h7F || hex0 !== 7'h7F || showing !== 1'b0) begin
            errors++;
            $display("FAIL reset: hex1=%h hex0=%h showing=%b expected 7f 7f 0", hex1, hex0, showing);
        end
        reset = 1'b0;
    endtask

    task automatic test_show();
        do_load(4'd4, 4'd7, 1'b0);
        checks++;
        if (hex1 !== 7'h7F || hex0 !== 7'h7F || showing !== 1'b0) begin
            errors++;
            $display("FAIL show_early: hex1=%h hex0=%h showing=%b expected 7f 7f 0", hex1, hex0, showing);
        end
        tick();
        checks++;
        if (hex1 !== 7'h19 || hex0 !== 7'h78 || showing !== 1'b1) begin
            errors++;
            $display("FAIL show_47: hex1=%h hex0=%h showing=%b expected 19 78 1", hex1, hex0, showing);
        end
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        do_load(4'd0, 4'd5, 1'b0);
        tick();
        checks++;
        if (hex1 !== 7'h7F || hex0 !== 7'h12) begin
            errors++;
            $display("FAIL blank_lz_on: hex1=%h hex0=%h expected 7f 12", hex1, hex0);
        end
        blank_lz = 1'b0;
        tick();
        checks++;
        if (hex1 !== 7'h40 || hex0 !== 7'h12) begin
            errors++;
            $display("FAIL blank_lz_off: hex1=%h hex0=%h expected 40 12", hex1, hex0);
        end
        // ones digit is never blanked: value 00 shows "0" in the ones place
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 1'b0);
        tick();
        checks++;
        if (hex1 !== 7'h7F || hex0 !== 7'h40) begin
            errors++;
            $display("FAIL blank_lz_zero: hex1=%h hex0=%h expected 7f 40", hex1, hex0);
        end
        blank_lz = 1'b0;
    endtask

    // Load must already have been applied; checks `cycles` outputs of the blink pattern
    task automatic check_blink(input string name, input int cycles);
        logic [6:0] e1, e0;
        for (int k = 1; k <= cycles; k++) begin
            tick();
            if (((k - 1) / 4) % 2 == 0) begin e1 = 7'h06; e0 = 7'h2F; end
            else                        begin e1 = 7'h7F; e0 = 7'h7F; end
            checks++;
            if (hex1 !== e1 || hex0 !== e0 || showing !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d]: hex1=%h hex0=%h showing=%b expected %h %h 1",
                         name, k, hex1, hex0, showing, e1, e0);
            end
        end
    endtask

    task automatic test_err();
        do_load(4'd1, 4'd1, 1'b1);
        check_blink("err_flag", 12);
        do_load(4'd10, 4'd0, 1'b0);
        check_blink("err_tens10", 6);
        do_load(4'd3, 4'd12, 1'b0);
        check_blink("err_ones12", 9);
    endtask

    task automatic test_reset_mid_err();
        do_load(4'd1, 4'd1, 1'b1);
        tick(); tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (hex1 !== 7'h7F || hex0 !== 7'h7F || showing !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_err[%0d]: hex1=%h hex0=%h showing=%b expected 7f 7f 0",
                         k, hex1, hex0, showing);
            end
        end
        reset = 1'b0;
        do_load(4'd0, 4'd0, 1'b1);
        check_blink("err_after_reset", 8);
    endtask

    task automatic test_load_clear();
        do_load(4'd2, 4'd3, 1'b0);
        tick();
        checks++;
        if (hex1 !== 7'h24 || hex0 !== 7'h30) begin
            errors++;
            $display("FAIL show_23: hex1=%h hex0=%h expected 24 30", hex1, hex0);
        end
        clear = 1'b1;
        do_load(4'd8, 4'd8, 1'b0);
        clear = 1'b0;
        tick();
        checks++;
        if (hex1 !== 7'h7F || hex0 !== 7'h7F || showing !== 1'b0) begin
            errors++;
            $display("FAIL load_clear: hex1=%h hex0=%h showing=%b expected 7f 7f 0", hex1, hex0, showing);
        end
        do_load(4'd5, 4'd5, 1'b1);
        tick(); tick(); tick();
        do_load(4'd9, 4'd9, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (hex1 !== 7'h10 || hex0 !== 7'h10 || showing !== 1'b1) begin
                errors++;
                $display("FAIL err_exit_99[%0d]: hex1=%h hex0=%h showing=%b expected 10 10 1",
                         k, hex1, hex0, showing);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_load(4'd1, 4'd2, 1'b0);
        do_load(4'd3, 4'd4, 1'b0);
        checks++;
        if (hex1 !== 7'h79 || hex0 !== 7'h24) begin
            errors++;
            $display("FAIL b2b_first: hex1=%h hex0=%h expected 79 24", hex1, hex0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (hex1 !== 7'h30 || hex0 !== 7'h19) begin
                errors++;
                $display("FAIL b2b_second[%0d]: hex1=%h hex0=%h expected 30 19", k, hex1, hex0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; clear = 1'b0; err = 1'b0; blank_lz = 1'b0;
        tens = '0; ones = '0;
        test_reset();
        test_show();
        test_blank_lz();
        test_err();
        test_reset_mid_err();
        test_load_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Downstream consumer of the binary-to-BCD stage. Accepts the tens/ones BCD digit pair plus the calculator overflow flag on a load strobe, and holds the captured value.
- Drives the two DE2-115 seven-segment digits, with optional leading-zero blanking.
- Shows a blinking "Er" on overflow or on an invalid BCD digit.
- Registered outputs; small FSM plus a blink counter.

Parameters:
- BLINK_HALF, default 25000000, cycles per blink half-period in ERR (0.5 s at 50 MHz); legal range >= 2.
- ACTIVE_LOW, default 1, 1 = segment outputs inverted (DE2-115 HEX pins are active-low).

Ports:
- clk1  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; capture tens/ones/err.
- clear  in  1  one-cycle strobe; return to blank display.
- tens  in  4  BCD tens digit from the converter.
- ones  in  4  BCD ones digit from the converter.
- err  in  1  calculator overflow/invalid result, sampled with load.
- blank_lz  in  1  level; 1 = blank the tens digit when it is 0.
- hex1  out  7  tens segments, bit6..0 = g,f,e,d,c,b,a.
- hex0  out  7  ones segments, same order.
- showing  out  1  1 while state is SHOW or ERR.

Behaviour:
- Reset (synchronous, active-high): state=BLANK, digit regs=0, blink counter=0, blink phase=on.
  - hex1=hex0=blank: 7'h7F if ACTIVE_LOW, else 7'h00.
  - showing=0.
- States: BLANK, SHOW, ERR.
- Transitions, evaluated every edge in priority order (clear > load):
  - clear=1: go to BLANK from any state. When load and clear are both high, clear wins and the load is discarded.
  - load=1 and (err=1 or tens>9 or ones>9): go to ERR. Blink counter=0, phase=on.
  - load=1 otherwise: go to SHOW and capture tens/ones. Valid from any state, including SHOW (overwrite) and ERR (exits error immediately).
  - No strobe: hold state.
- Latency:
  - The load edge updates state and digit regs.
  - hex1/hex0/showing are registered from those, so they change on the 2nd edge after load is sampled.
  - clear has the same 2-cycle latency.
- Segment encodes (active-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 'E'=79, 'r'=50, blank=00.
  - ACTIVE_LOW=1 inverts all 7 bits.
- SHOW: hex1=enc(tens), hex0=enc(ones).
  - If blank_lz=1 and tens==0, hex1=blank.
  - The ones digit is never blanked, so value 0 shows "0".
  - blank_lz is level-sensitive and re-evaluated every cycle.
- ERR: hex1='E', hex0='r' while phase=on; both blank while phase=off.
  - Blink counter counts 0..BLINK_HALF-1. At BLINK_HALF-1 it wraps to 0 and toggles phase.
  - First "off" begins BLINK_HALF cycles after entry.
  - Counter is held at 0 in BLANK and SHOW.
- A load that re-enters ERR while already in ERR restarts the counter and sets phase=on.
- Reset asserted mid-blink or mid-pipeline overrides everything. Outputs are blank 1 edge after reset is sampled.
- Digit regs hold their last value in BLANK and ERR. They are not cleared except by reset.

Decomposition:
- Shared package (calc_pkg):
  - state enum {BLANK, SHOW, ERR}.
  - Segment constants SEG_0..SEG_9, SEG_E, SEG_R, SEG_BLANK (active-high).
  - Width constants BCD_W=4 and SEG_W=7.
- One sub-module: seg7_encode, purely combinational.
  - Inputs: 4-bit digit, blank flag, ACTIVE_LOW.
  - Output: 7-bit segments.
  - Instantiated twice.
- The FSM, blink counter and output registers stay in the top.

Test Plan:
- Reset with ACTIVE_LOW=1 -> hex1=hex0=7'h7F, showing=0; hold reset 3 cycles mid-ERR -> same values, counter=0.
- load with tens=4, ones=7, err=0 -> 2 edges later hex1=7'h19 (~66), hex0=7'h78 (~07), showing=1; no change before the 2nd edge.
- blank_lz=1, load 0/5 -> hex1=7'h7F, hex0=7'h12; drop blank_lz -> hex1=7'h40 the following cycles.
- load with err=1 (BLINK_HALF=4) -> hex1=7'h06, hex0=7'h2F for 4 cycles, then 7'h7F/7'h7F for 4, repeating; load tens=10 -> same ERR behaviour.
- load and clear in the same cycle while in SHOW -> BLANK, hex=7'h7F, captured digits unchanged; then load 9/9 from ERR -> hex1=hex0=7'h10, blinking stops.
- Back-to-back loads 1/2 then 3/4 on consecutive cycles -> outputs show 1/2 for exactly one cycle, then 3/4.
